// File: rtl/line_engine_if.sv
// Command and pixel-write bundle for line_engine. The engine is the master: it
// takes the CPU line commands and offers framebuffer writes to the arbiter.
interface line_engine_if;
  logic [9:0]  line_point;
  logic        line_x0_valid;
  logic        line_y0_valid;
  logic        line_x1_valid;
  logic        line_y1_valid;
  logic [31:0] line_color;
  logic        line_color_valid;
  logic        line_trigger;
  logic        line_ready;
  logic [31:0] px_addr;
  logic [31:0] px_data;
  logic [3:0]  px_we;
  logic        px_valid;
  logic        px_ready;

  modport master (
    input  line_point, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid,
    input  line_color, line_color_valid, line_trigger, px_ready,
    output line_ready, px_addr, px_data, px_we, px_valid
  );

  modport slave (
    output line_point, line_x0_valid, line_y0_valid, line_x1_valid, line_y1_valid,
    output line_color, line_color_valid, line_trigger, px_ready,
    input  line_ready, px_addr, px_data, px_we, px_valid
  );
endinterface

// File: rtl/line_engine.sv
// Bresenham line rasterizer: snapshots CPU shadow registers on trigger and
// streams one framebuffer write per plotted pixel over a ready/valid port.
module line_engine #(
  parameter logic [31:0] FB_BASE   = 32'h1080_0000,
  parameter int          ROW_SHIFT = 10
) (
  input logic          clk,
  input logic          rst_n,
  line_engine_if.master lif
);
  typedef enum logic [1:0] {IDLE, SWAP, INIT, DRAW} state_e;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic [9:0]         sh_x0_q, sh_x0_d, sh_y0_q, sh_y0_d, sh_x1_q, sh_x1_d, sh_y1_q, sh_y1_d;
  logic [31:0]        sh_col_q, sh_col_d;
  logic [9:0]         x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [31:0]        col_q, col_d;
  logic               steep_q, steep_d, yneg_q, yneg_d;
  logic [9:0]         dx_q, dx_d, dy_q, dy_d, cx_q, cx_d, cy_q, cy_d;
  logic signed [11:0] err_q, err_d;
  logic               vld_q, vld_d;
  logic [31:0]        addr_q, addr_d, data_q, data_d;
  logic [3:0]         we_q, we_d;

  logic [9:0]         adx, ady, a0, b0, a1, b1, cy_nx;
  logic               steep, hs;
  logic signed [11:0] err_nx;

  function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Cursor lives in the swapped (steep) frame; undo the swap when forming the address.
  function automatic logic [31:0] pix_addr(input logic [9:0] px, input logic [9:0] py,
                                           input logic stp);
    logic [31:0] sx, sy;
    sx = {22'd0, stp ? py : px};
    sy = {22'd0, stp ? px : py};
    return FB_BASE + (((sy << ROW_SHIFT) + sx) << 2);
  endfunction

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    sh_x0_d  = lif.line_x0_valid    ? lif.line_point : sh_x0_q;
    sh_y0_d  = lif.line_y0_valid    ? lif.line_point : sh_y0_q;
    sh_x1_d  = lif.line_x1_valid    ? lif.line_point : sh_x1_q;
    sh_y1_d  = lif.line_y1_valid    ? lif.line_point : sh_y1_q;
    sh_col_d = lif.line_color_valid ? lif.line_color : sh_col_q;
    x0_d = x0_q; y0_d = y0_q; x1_d = x1_q; y1_d = y1_q; col_d = col_q;
    steep_d = steep_q; yneg_d = yneg_q;
    dx_d = dx_q; dy_d = dy_q; err_d = err_q; cx_d = cx_q; cy_d = cy_q;
    vld_d = vld_q; addr_d = addr_q; data_d = data_q; we_d = we_q;

    adx   = absdiff(x1_q, x0_q);
    ady   = absdiff(y1_q, y0_q);
    steep = ady > adx;
    a0 = steep ? y0_q : x0_q;
    b0 = steep ? x0_q : y0_q;
    a1 = steep ? y1_q : x1_q;
    b1 = steep ? x1_q : y1_q;

    err_nx = err_q - $signed({2'b00, dy_q});
    cy_nx  = cy_q;
    if (err_nx[11]) begin
      err_nx = err_nx + $signed({2'b00, dx_q});
      cy_nx  = yneg_q ? cy_q - 10'd1 : cy_q + 10'd1;
    end
    hs = vld_q & lif.px_ready;

    case (state_q)
      IDLE: if (lif.line_trigger) begin
        x0_d = sh_x0_q; y0_d = sh_y0_q; x1_d = sh_x1_q; y1_d = sh_y1_q;
        col_d   = sh_col_q;
        ready_d = 1'b0;
        state_d = SWAP;
      end
      SWAP: begin
        steep_d = steep;
        if (a0 > a1) begin
          x0_d = a1; y0_d = b1; x1_d = a0; y1_d = b0;
        end else begin
          x0_d = a0; y0_d = b0; x1_d = a1; y1_d = b1;
        end
        state_d = INIT;
      end
      INIT: begin
        dx_d    = x1_q - x0_q;
        dy_d    = ady;
        err_d   = $signed({3'b000, dx_d[9:1]});
        yneg_d  = ~(y0_q < y1_q);
        cx_d    = x0_q;
        cy_d    = y0_q;
        state_d = DRAW;
      end
      DRAW: begin
        if (!vld_q) begin
          // First pixel: present the starting cursor.
          vld_d  = 1'b1;
          we_d   = 4'hF;
          addr_d = pix_addr(cx_q, cy_q, steep_q);
          data_d = col_q;
        end else if (hs) begin
          if (cx_q == x1_q) begin
            vld_d   = 1'b0;
            we_d    = 4'h0;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            cx_d   = cx_q + 10'd1;
            cy_d   = cy_nx;
            err_d  = err_nx;
            addr_d = pix_addr(cx_q + 10'd1, cy_nx, steep_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      sh_x0_q  <= '0; sh_y0_q <= '0; sh_x1_q <= '0; sh_y1_q <= '0; sh_col_q <= '0;
      x0_q     <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0; col_q <= '0;
      steep_q  <= 1'b0; yneg_q <= 1'b0;
      dx_q     <= '0; dy_q <= '0; err_q <= '0; cx_q <= '0; cy_q <= '0;
      vld_q    <= 1'b0; addr_q <= '0; data_q <= '0; we_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      sh_x0_q  <= sh_x0_d; sh_y0_q <= sh_y0_d; sh_x1_q <= sh_x1_d; sh_y1_q <= sh_y1_d;
      sh_col_q <= sh_col_d;
      x0_q     <= x0_d; y0_q <= y0_d; x1_q <= x1_d; y1_q <= y1_d; col_q <= col_d;
      steep_q  <= steep_d; yneg_q <= yneg_d;
      dx_q     <= dx_d; dy_q <= dy_d; err_q <= err_d; cx_q <= cx_d; cy_q <= cy_d;
      vld_q    <= vld_d; addr_q <= addr_d; data_q <= data_d; we_q <= we_d;
    end
  end

  assign lif.line_ready = ready_q;
  assign lif.px_valid   = vld_q;
  assign lif.px_addr    = addr_q;
  assign lif.px_data    = data_q;
  assign lif.px_we      = we_q;
endmodule

// File: doc/line_engine.md
# line_engine

Hardware line rasterizer that answers the CPU's line-drawing command interface (`line_point`, `line_*_valid`, `line_color_valid`, `line_trigger`, `line_ready`).
- It latches endpoints and a color, then runs Bresenham's algorithm.
- It emits one framebuffer pixel write per plotted point on a ready/valid port toward the memory architecture's write arbiter.
- It sits between the Riscv150 CPU's memory-mapped line registers and Memory150, in the CPU clock domain.

## Interface
- `FB_BASE`, default 32'h1080_0000: byte address of framebuffer pixel (0,0).
- `ROW_SHIFT`, default 10: log2 of the row stride in pixels (1024 px/row, 4 bytes/px).
- `clk`  in  1  CPU clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `line_point`  in  10  unsigned coordinate value qualified by one of the four valid strobes below.
- `line_x0_valid`, `line_y0_valid`, `line_x1_valid`, `line_y1_valid`  in  1 each  load `line_point` into the matching shadow register.
- `line_color`  in  32  pixel color.
- `line_color_valid`  in  1  load `line_color` into the shadow color register.
- `line_trigger`  in  1  start a draw; single-cycle pulse.
- `line_ready`  out  1  engine idle; a trigger will be accepted.
- `px_addr`  out  32  byte address of the current pixel.
- `px_data`  out  32  pixel color.
- `px_we`  out  4  byte enables; 4'hF whenever `px_valid` is high, else 0.
- `px_valid`  out  1  a pixel write is offered.
- `px_ready`  in  1  the consumer accepts the write.

## Operation
- **Shadow registers** (x0, y0, x1, y1, color):
  - They load on their strobe in any state, including while a draw is in progress.
  - A draw uses a snapshot taken at trigger, so the CPU can preload the next line.
- **Trigger acceptance:** a trigger is accepted only when `line_ready`=1. A trigger while busy is ignored and never queued.
- **FSM: IDLE → SWAP → INIT → DRAW → IDLE.**
  - **IDLE:**
    - `line_ready`=1.
    - On trigger, snapshot the shadow registers and go to SWAP.
  - **SWAP:**
    - steep = |y1−y0| > |x1−x0|. If steep, exchange x with y in both endpoints.
    - Then, if x0 > x1, exchange the two endpoints.
  - **INIT:**
    - dx = x1−x0 (unsigned, ≥0) and dy = |y1−y0|.
    - err = dx>>1, held as a signed 12-bit value.
    - ystep = +1 if y0<y1, else −1.
    - Cursor (x,y) = (x0,y0). Go to DRAW.
  - **DRAW:**
    - Plotted screen point: (sx,sy) = steep ? (y,x) : (x,y).
    - px_addr = FB_BASE + (((sy<<ROW_SHIFT) + sx) << 2), computed at 32 bits.
    - On the handshake (`px_valid` & `px_ready`), if x == x1, go to IDLE.
    - Otherwise, on the handshake: x += 1; err −= dy; if the new err < 0, then y += ystep and err += dx.
- **Pixel count:** max(|dx|,|dy|)+1, with no duplicates or omissions. A degenerate line (both endpoints equal) emits exactly 1 pixel.
- **Coordinate arithmetic:**
  - Coordinates are 10-bit unsigned.
  - Differences are 11-bit signed before the absolute value is taken.
  - No clipping: any 10-bit coordinate yields an address per the formula above.

## Timing
- **Reset values** (rst_n low, applied immediately and asynchronously):
  - FSM in IDLE, `line_ready`=1.
  - `px_valid`=0, `px_we`=0, `px_addr`=0, `px_data`=0.
  - All shadow registers = 0.
- **Reset mid-draw:** the current line is abandoned and no further pixels are emitted. After release, the engine accepts a new trigger normally.
- **Start latency:**
  - Trigger sampled at edge T.
  - `line_ready` goes low after edge T.
  - SWAP runs in cycle T+1 and INIT in cycle T+2.
  - `px_valid` first goes high after edge T+3.
- **Throughput:** with `px_ready` held at 1, one pixel per cycle.
- **Backpressure:**
  - While `px_valid`=1 and `px_ready`=0, `px_addr`, `px_data` and `px_we` hold stable.
  - `px_valid` never drops without a handshake.
- **Completion:**
  - After the handshake of the last pixel, `px_valid`=0 and `line_ready`=1 on the next cycle.
  - A trigger in that same cycle is accepted.
- **Shadow-register timing:**
  - A strobe in the same cycle as an accepted trigger is not part of the snapshot; it applies to the next line.
  - A shadow write during DRAW does not alter the in-flight line.
- **Registered outputs:** `px_*` and `line_ready` are registered, with no combinational path from `px_ready` to `px_valid`.

## Test plan
1. **Horizontal line.**
   - Stimulus: (0,0)→(3,0), color 32'h00FF0000, `px_ready`=1.
   - Response: 4 writes at FB_BASE+0x0, +0x4, +0x8, +0xC with data 32'h00FF0000 and `px_we`=4'hF.
   - First `px_valid` 3 cycles after the trigger; `line_ready` returns 1 cycle after the last handshake.
2. **Steep, reversed line.**
   - Stimulus: (2,5)→(0,0).
   - Response: pixels (x,y) = (0,0), (0,1), (1,2), (1,3), (2,4), (2,5), in that order.
3. **Backpressure.**
   - Stimulus: (0,0)→(4,4); hold `px_ready`=0 for 5 cycles after each valid, plus random toggling.
   - Response: outputs stable while stalled; exactly 5 pixels on the diagonal (i,i); no duplicates.
4. **Single point.**
   - Stimulus: (7,7)→(7,7).
   - Response: exactly one write at FB_BASE+32'h701C.
5. **Busy-time inputs.**
   - Stimulus: trigger and shadow writes (x1 ← 9) issued mid-draw of (0,0)→(3,0).
   - Response: the current line is still 4 pixels ending at x=3 and the busy trigger is ignored. The next trigger draws (0,0)→(9,0), 10 pixels.
6. **Reset mid-draw.**
   - Stimulus: rst_n pulsed low during pixel 2 of a 10-pixel line.
   - Response: `px_valid`=0 and `line_ready`=1 immediately; shadows = 0; a subsequent trigger draws from (0,0).
